// File: rtl/timer_controller.sv
// Moore control FSM for the egg-timer: set seconds, set minutes, wait, run, done.
// Drives time-register enables and the display flash from the state register alone.
module timer_controller (
  input  logic clk,
  input  logic reset,
  input  logic set,
  input  logic startStop,
  input  logic isTimeFlat,
  output logic flashEn,
  output logic decEn,
  output logic timeWrtEn,
  output logic initValEn,
  output logic minEn
);

  localparam logic [2:0] S_SET_SECS = 3'd0;
  localparam logic [2:0] S_SET_MINS = 3'd1;
  localparam logic [2:0] S_WAIT     = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0] r_state;
  logic [2:0] w_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_SET_SECS;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = S_SET_SECS;
    case (r_state)
      S_SET_SECS: w_next = set ? S_SET_MINS : S_SET_SECS;
      S_SET_MINS: w_next = set ? S_WAIT : S_SET_MINS;
      S_WAIT:     w_next = (startStop && !isTimeFlat) ? S_RUN : S_WAIT;
      // Reaching zero beats a simultaneous pause request.
      S_RUN: begin
        if (isTimeFlat) begin
          w_next = S_DONE;
        end else if (startStop) begin
          w_next = S_WAIT;
        end else begin
          w_next = S_RUN;
        end
      end
      S_DONE:     w_next = startStop ? S_WAIT : S_DONE;
      default:    w_next = S_SET_SECS;
    endcase
  end

  always_comb begin
    flashEn   = 1'b0;
    decEn     = 1'b0;
    timeWrtEn = 1'b0;
    initValEn = 1'b0;
    minEn     = 1'b0;
    case (r_state)
      S_SET_SECS: begin
        timeWrtEn = 1'b1;
        initValEn = 1'b1;
      end
      S_SET_MINS: begin
        timeWrtEn = 1'b1;
        initValEn = 1'b1;
        minEn     = 1'b1;
      end
      S_RUN: begin
        decEn     = 1'b1;
        timeWrtEn = 1'b1;
      end
      S_DONE:  flashEn = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_timer_controller.sv
// Bench for timer_controller: directed walk through the control flow, then random
// inputs compared each cycle against a rule-level reference model.
module tb_timer_controller;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic set = 1'b0;
  logic startStop = 1'b0;
  logic isTimeFlat = 1'b0;
  logic flashEn, decEn, timeWrtEn, initValEn, minEn;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: mode names as plain integers, outputs from a lookup table.
  localparam int M_SECS = 0, M_MINS = 1, M_WAIT = 2, M_RUN = 3, M_DONE = 4;
  int m_mode = M_SECS;
  logic [4:0] m_out_tbl [0:4];

  timer_controller dut (
    .clk(clk), .reset(reset), .set(set), .startStop(startStop),
    .isTimeFlat(isTimeFlat), .flashEn(flashEn), .decEn(decEn),
    .timeWrtEn(timeWrtEn), .initValEn(initValEn), .minEn(minEn)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (mode %0d)", tag, got, exp, m_mode);
    end
  endtask

  function automatic int model_next(int mode, logic r, logic s, logic ss, logic f);
    if (r) return M_SECS;
    if (mode == M_SECS) return s ? M_MINS : M_SECS;
    if (mode == M_MINS) return s ? M_WAIT : M_MINS;
    if (mode == M_WAIT) return (ss && !f) ? M_RUN : M_WAIT;
    if (mode == M_RUN)  return f ? M_DONE : (ss ? M_WAIT : M_RUN);
    if (mode == M_DONE) return ss ? M_WAIT : M_DONE;
    return M_SECS;
  endfunction

  // One clock: drive on falling edge, advance model at rising edge, sample 1 ns later.
  task automatic step(input string tag, input logic r, input logic s, input logic ss, input logic f);
    @(negedge clk);
    reset = r; set = s; startStop = ss; isTimeFlat = f;
    @(posedge clk);
    m_mode = model_next(m_mode, r, s, ss, f);
    #1;
    check_vec(tag, {flashEn, decEn, timeWrtEn, initValEn, minEn}, m_out_tbl[m_mode]);
  endtask

  task automatic idle3(input string tag);
    for (int k = 0; k < 3; k++) step(tag, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // {flashEn, decEn, timeWrtEn, initValEn, minEn}
    m_out_tbl[M_SECS] = 5'b00110;
    m_out_tbl[M_MINS] = 5'b00111;
    m_out_tbl[M_WAIT] = 5'b00000;
    m_out_tbl[M_RUN]  = 5'b01100;
    m_out_tbl[M_DONE] = 5'b10000;

    step("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    check_vec("reset_const", {flashEn, decEn, timeWrtEn, initValEn, minEn}, 5'b00110);
    idle3("hold_secs");
    step("set_beats_ss_1", 1'b0, 1'b1, 1'b1, 1'b0);
    check_vec("mins_const", {flashEn, decEn, timeWrtEn, initValEn, minEn}, 5'b00111);
    idle3("hold_mins");
    step("set_beats_ss_2", 1'b0, 1'b1, 1'b1, 1'b0);
    idle3("hold_wait");
    step("start", 1'b0, 1'b0, 1'b1, 1'b0);
    check_vec("run_const", {flashEn, decEn, timeWrtEn, initValEn, minEn}, 5'b01100);
    step("pause", 1'b0, 1'b0, 1'b1, 1'b0);
    step("set_in_wait", 1'b0, 1'b1, 1'b0, 1'b0);
    step("restart", 1'b0, 1'b0, 1'b1, 1'b0);
    idle3("hold_run");
    step("flat_beats_ss", 1'b0, 1'b0, 1'b1, 1'b1);
    check_vec("done_const", {flashEn, decEn, timeWrtEn, initValEn, minEn}, 5'b10000);
    idle3("hold_done");
    step("set_in_done", 1'b0, 1'b1, 1'b0, 1'b0);
    step("done_to_wait", 1'b0, 1'b0, 1'b1, 1'b0);
    step("start_when_flat", 1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) step("toggle", 1'b0, 1'b0, 1'b1, 1'b0);
    step("reset_in_wait", 1'b1, 1'b1, 1'b1, 1'b1);
    step("to_mins", 1'b0, 1'b1, 1'b0, 1'b0);
    step("to_wait", 1'b0, 1'b1, 1'b0, 1'b0);
    step("to_run", 1'b0, 1'b0, 1'b1, 1'b0);
    step("reset_in_run", 1'b1, 1'b1, 1'b1, 1'b1);
    check_vec("reset_run_const", {flashEn, decEn, timeWrtEn, initValEn, minEn}, 5'b00110);
    step("to_mins2", 1'b0, 1'b1, 1'b0, 1'b0);
    step("to_wait2", 1'b0, 1'b1, 1'b0, 1'b0);
    step("to_run2", 1'b0, 1'b0, 1'b1, 1'b0);
    step("to_done2", 1'b0, 1'b0, 1'b0, 1'b1);
    step("reset_in_done", 1'b1, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      step("random",
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
